// File: rtl/spm_pkg.sv
// Shared types and sizing constants for the serial-parallel multiplier and its controller.
package spm_pkg;
    localparam int SPM_SIZE  = 32;
    localparam int SPM_P_LAT = 1;
    localparam int PROD_W    = 2 * SPM_SIZE;
    localparam int CNT_W     = $clog2(PROD_W + SPM_P_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/spm_deser.sv
// Right-shift capture register: serial bits enter at the MSB, so the first bit captured ends in bit 0.
module spm_deser #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         shift_en_i,
    input  logic         bit_i,
    output logic [W-1:0] data_o
);
    logic [W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i)
            data_d = '0;
        else if (shift_en_i)
            data_d = {bit_i, data_q[W-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign data_o = data_q;
endmodule

// File: rtl/spm_seq_ctrl.sv
// Feeds operands to the serial-parallel multiplier and deserialises its product.
module spm_seq_ctrl
    import spm_pkg::*;
#(
    parameter int SIZE  = SPM_SIZE,
    parameter int P_LAT = SPM_P_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_a,
    input  logic [SIZE-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] out_prod,
    output logic              spm_clr,
    output logic [SIZE-1:0]   spm_x,
    output logic              spm_y,
    input  logic              spm_p
);
    localparam int PW = 2 * SIZE;
    localparam int CW = $clog2(PW + P_LAT + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] x_q, x_d, y_q, y_d;
    logic            clr_q, clr_d;
    logic            accept, cap_en, busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_CLR;
            ST_CLR:   state_d = ST_RUN;
            ST_RUN:   if (cnt_q == CW'(PW - 1)) state_d = (P_LAT == 0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (cnt_q == CW'(PW + P_LAT - 1)) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        spm_y     = busy ? y_q[0] : 1'b0;
        // spm_p lags spm_y by P_LAT, so capture starts P_LAT cycles into RUN.
        cap_en    = ((state_q == ST_RUN) && (cnt_q >= CW'(P_LAT))) || (state_q == ST_DRAIN);
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        cnt_d = cnt_q;
        clr_d = (state_d == ST_CLR);
        if (accept) begin
            x_d   = in_a;
            y_d   = in_b;
            cnt_d = '0;
        end else if (busy) begin
            // Arithmetic shift keeps presenting the sign bit once b is exhausted.
            y_d   = {y_q[SIZE-1], y_q[SIZE-1:1]};
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
            clr_q <= 1'b1;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
            clr_q <= clr_d;
        end
    end

    assign spm_clr = clr_q;
    assign spm_x   = x_q;

    spm_deser #(.W(PW)) u_deser (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .shift_en_i (cap_en),
        .bit_i      (spm_p),
        .data_o     (out_prod)
    );
endmodule
